// File: rtl/ctrl_decode_pipe.sv
// MIPS-subset decode stage: decodes the ID instruction into the control bundle, registers it
// into ID/EX, and owns load-use bubbles, flush/stall handling and the exit-syscall halt FSM.
module ctrl_decode_pipe #(
   parameter int unsigned ALUOP_W   = 4,
   parameter int unsigned DRAIN_CYC = 3,
   parameter bit          EN_SH     = 1'b1,
   parameter bit          EN_BLEZ   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr_i,
   input  logic                 id_valid_i,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 v0_is_ten_i,
   output logic [ALUOP_W+14:0]  ex_ctrl_o,
   output logic                 ex_valid_o,
   output logic [4:0]           ex_wreg_o,
   output logic                 ex_illegal_o,
   output logic                 load_use_o,
   output logic                 halted_o
);

   localparam int unsigned CtrlW  = ALUOP_W + 15;
   localparam int unsigned CntW   = 4;
   localparam int unsigned PosMtr = ALUOP_W + 5;
   localparam int unsigned PosSys = ALUOP_W + 14;

   localparam logic [ALUOP_W-1:0] AluSll  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] AluSra  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] AluSrl  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] AluNor  = ALUOP_W'(10);
   localparam logic [ALUOP_W-1:0] AluSlt  = ALUOP_W'(11);
   localparam logic [ALUOP_W-1:0] AluSltu = ALUOP_W'(12);
   localparam logic [ALUOP_W-1:0] AluNone = ALUOP_W'(13);

   localparam logic [1:0] ExtSign  = 2'b00;
   localparam logic [1:0] ExtZero  = 2'b01;
   localparam logic [1:0] ExtShamt = 2'b10;

   localparam logic [CtrlW-1:0] BubbleCtrl = CtrlW'({AluNone, 2'b00});

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   logic [5:0] op, fn;
   logic [4:0] rs, rt, rd;
   logic       unused_shamt;

   assign op = instr_i[31:26];
   assign rs = instr_i[25:21];
   assign rt = instr_i[20:16];
   assign rd = instr_i[15:11];
   assign fn = instr_i[5:0];
   assign unused_shamt = ^instr_i[10:6];

   logic [ALUOP_W-1:0] aluop;
   logic [1:0]         extop;
   logic reg_dst, alu_src, reg_wr, mem_to_reg, mem_wr;
   logic is_sh, is_blez, is_beq, is_bne, is_j, is_jal, is_jr, is_sys, dec_illegal;
   logic [CtrlW-1:0]   dec_ctrl;
   logic [4:0]         dec_wreg;
   logic               rt_use;

   always_comb begin
      aluop = AluNone;
      extop = ExtSign;
      reg_dst = 1'b0; alu_src = 1'b0; reg_wr = 1'b0; mem_to_reg = 1'b0; mem_wr = 1'b0;
      is_sh = 1'b0; is_blez = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
      is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_sys = 1'b0;
      dec_illegal = 1'b0;
      case (op)
         6'h00: begin
            case (fn)
               6'h00, 6'h02, 6'h03: begin
                  aluop   = (fn == 6'h00) ? AluSll : (fn == 6'h03) ? AluSra : AluSrl;
                  extop   = ExtShamt;
                  alu_src = 1'b1;
                  reg_dst = 1'b1;
                  reg_wr  = 1'b1;
               end
               6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b: begin
                  reg_dst = 1'b1;
                  reg_wr  = 1'b1;
                  case (fn)
                     6'h22:   aluop = AluSub;
                     6'h24:   aluop = AluAnd;
                     6'h25:   aluop = AluOr;
                     6'h27:   aluop = AluNor;
                     6'h2a:   aluop = AluSlt;
                     6'h2b:   aluop = AluSltu;
                     default: aluop = AluAdd;
                  endcase
               end
               6'h08:   is_jr  = 1'b1;
               6'h0c:   is_sys = 1'b1;
               default: dec_illegal = 1'b1;
            endcase
         end
         6'h02: is_j = 1'b1;
         6'h03: begin
            is_jal = 1'b1;
            reg_wr = 1'b1;
         end
         6'h04: is_beq = 1'b1;
         6'h05: is_bne = 1'b1;
         6'h06: begin
            if (EN_BLEZ) is_blez = 1'b1;
            else         dec_illegal = 1'b1;
         end
         6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d: begin
            alu_src = 1'b1;
            reg_wr  = 1'b1;
            case (op)
               6'h0a:   aluop = AluSlt;
               6'h0c:   begin aluop = AluAnd; extop = ExtZero; end
               6'h0d:   begin aluop = AluOr;  extop = ExtZero; end
               default: aluop = AluAdd;
            endcase
         end
         6'h23: begin
            aluop = AluAdd; alu_src = 1'b1; reg_wr = 1'b1; mem_to_reg = 1'b1;
         end
         6'h2b: begin
            aluop = AluAdd; alu_src = 1'b1; mem_wr = 1'b1;
         end
         6'h29: begin
            if (EN_SH) begin
               aluop = AluAdd; alu_src = 1'b1; mem_wr = 1'b1; is_sh = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign dec_ctrl = {is_sys, is_jr, is_jal, is_j, is_bne, is_beq, is_blez, is_sh, mem_wr,
                      mem_to_reg, reg_wr, alu_src, reg_dst, aluop, extop};
   assign dec_wreg = reg_dst ? rd : (is_jal ? 5'd31 : rt);
   assign rt_use   = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
                     (op == 6'h2b) || (op == 6'h29);

   logic [CtrlW-1:0] ctrl_q, ctrl_d;
   logic             valid_q, valid_d, illegal_q, illegal_d;
   logic [4:0]       wreg_q, wreg_d;
   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   assign load_use_o = id_valid_i & valid_q & ctrl_q[PosMtr] & (wreg_q != 5'd0) &
                       ((wreg_q == rs) | (rt_use & (wreg_q == rt)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            if (valid_q && ctrl_q[PosSys] && v0_is_ten_i && !stall_i) begin
               state_d = StDrain;
               cnt_d   = CntW'(DRAIN_CYC - 1);
            end
         end
         StDrain: begin
            if (cnt_q == '0) state_d = StHalted;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StHalted: state_d = StHalted;
         default:  state_d = StRun;
      endcase
   end

   // Draining/halted bubbles win over stall so the pipe empties even if held.
   always_comb begin
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      wreg_d    = wreg_q;
      if (flush_i || (state_q != StRun) || (!stall_i && load_use_o)) begin
         ctrl_d    = BubbleCtrl;
         valid_d   = 1'b0;
         illegal_d = 1'b0;
         wreg_d    = 5'd0;
      end else if (!stall_i) begin
         ctrl_d    = dec_ctrl;
         valid_d   = id_valid_i;
         illegal_d = id_valid_i & dec_illegal;
         wreg_d    = dec_wreg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         wreg_q    <= 5'd0;
         state_q   <= StRun;
         cnt_q     <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         wreg_q    <= wreg_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ex_ctrl_o    = ctrl_q;
   assign ex_valid_o   = valid_q;
   assign ex_illegal_o = illegal_q;
   assign ex_wreg_o    = wreg_q;
   assign halted_o     = (state_q == StHalted);

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: a default instance and a reduced one (no sh/blez, one drain cycle)
// share stimulus and are both checked each cycle against a mnemonic-level model.
module tb_ctrl_decode_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        id_valid, stall, flush, v0_ten;

   logic [18:0] d0_ctrl, d1_ctrl;
   logic        d0_valid, d1_valid, d0_ill, d1_ill, d0_lu, d1_lu, d0_halt, d1_halt;
   logic [4:0]  d0_wreg, d1_wreg;

   int n_vec = 0;
   int n_err = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   ctrl_decode_pipe dut (
      .clk(clk), .rst_n(rst_n), .instr_i(instr), .id_valid_i(id_valid), .stall_i(stall),
      .flush_i(flush), .v0_is_ten_i(v0_ten), .ex_ctrl_o(d0_ctrl), .ex_valid_o(d0_valid),
      .ex_wreg_o(d0_wreg), .ex_illegal_o(d0_ill), .load_use_o(d0_lu), .halted_o(d0_halt)
   );

   ctrl_decode_pipe #(.ALUOP_W(4), .DRAIN_CYC(1), .EN_SH(1'b0), .EN_BLEZ(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .instr_i(instr), .id_valid_i(id_valid), .stall_i(stall),
      .flush_i(flush), .v0_is_ten_i(v0_ten), .ex_ctrl_o(d1_ctrl), .ex_valid_o(d1_valid),
      .ex_wreg_o(d1_wreg), .ex_illegal_o(d1_ill), .load_use_o(d1_lu), .halted_o(d1_halt)
   );

   typedef struct packed {
      logic sys, jr, jal, j, bne, beq, blez, sh, mw, mtr, rw, as, rd;
      logic [3:0] alu;
      logic [1:0] ext;
   } ctrl_t;

   localparam logic [31:0] ADD1   = 32'h00221820; // add $3,$1,$2
   localparam logic [31:0] ADD2   = 32'h00421820; // add $3,$2,$2
   localparam logic [31:0] ADD0   = 32'h00001820; // add $3,$0,$0
   localparam logic [31:0] LW     = 32'h8C220000; // lw $2,0($1)
   localparam logic [31:0] LW0    = 32'h8C200000; // lw $0,0($1)
   localparam logic [31:0] SW_RT  = 32'hACA20000; // sw $2,0($5)
   localparam logic [31:0] ADDI_RT = 32'h20620001; // addi $2,$3,1
   localparam logic [31:0] ORI    = 32'h34251234; // ori $5,$1,0x1234
   localparam logic [31:0] JAL    = 32'h0C000010;
   localparam logic [31:0] JR     = 32'h03E00008;
   localparam logic [31:0] SH     = 32'hA4220004;
   localparam logic [31:0] BLEZ   = 32'h18200008;
   localparam logic [31:0] SYS    = 32'h0000000C;

   // ---------------- model ----------------
   function automatic string mnem(input logic [31:0] ins, input bit en_sh, input bit en_blez);
      string m;
      m = "ill";
      if (ins[31:26] == 6'h00) begin
         case (ins[5:0])
            6'h00: m = "sll";  6'h02: m = "srl";  6'h03: m = "sra";
            6'h20: m = "add";  6'h21: m = "addu"; 6'h22: m = "sub";
            6'h24: m = "and";  6'h25: m = "or";   6'h27: m = "nor";
            6'h2a: m = "slt";  6'h2b: m = "sltu"; 6'h08: m = "jr";
            6'h0c: m = "syscall";
            default: m = "ill";
         endcase
      end else begin
         case (ins[31:26])
            6'h02: m = "j";     6'h03: m = "jal";   6'h04: m = "beq";  6'h05: m = "bne";
            6'h06: m = en_blez ? "blez" : "ill";
            6'h08: m = "addi";  6'h09: m = "addiu"; 6'h0a: m = "slti";
            6'h0c: m = "andi";  6'h0d: m = "ori";   6'h23: m = "lw";   6'h2b: m = "sw";
            6'h29: m = en_sh ? "sh" : "ill";
            default: m = "ill";
         endcase
      end
      return m;
   endfunction

   function automatic ctrl_t ref_ctrl(input string m);
      ctrl_t c;
      c = '0;
      case (m)
         "sll": c.alu = 4'd0;  "sra": c.alu = 4'd1;  "srl": c.alu = 4'd2;
         "add", "addu", "addi", "addiu", "lw", "sw", "sh": c.alu = 4'd5;
         "sub": c.alu = 4'd6;  "and", "andi": c.alu = 4'd7;  "or", "ori": c.alu = 4'd8;
         "nor": c.alu = 4'd10; "slt", "slti": c.alu = 4'd11; "sltu": c.alu = 4'd12;
         default: c.alu = 4'd13;
      endcase
      case (m)
         "sll", "srl", "sra": begin c.rd = 1; c.rw = 1; c.as = 1; c.ext = 2'b10; end
         "add", "addu", "sub", "and", "or", "nor", "slt", "sltu": begin c.rd = 1; c.rw = 1; end
         "addi", "addiu", "slti": begin c.as = 1; c.rw = 1; end
         "andi", "ori": begin c.as = 1; c.rw = 1; c.ext = 2'b01; end
         "lw":  begin c.as = 1; c.rw = 1; c.mtr = 1; end
         "sw":  begin c.as = 1; c.mw = 1; end
         "sh":  begin c.as = 1; c.mw = 1; c.sh = 1; end
         "jr":  c.jr = 1;
         "syscall": c.sys = 1;
         "j":   c.j = 1;
         "jal": begin c.jal = 1; c.rw = 1; end
         "beq": c.beq = 1;  "bne": c.bne = 1;  "blez": c.blez = 1;
         default: ;
      endcase
      return c;
   endfunction

   ctrl_t      m_ctrl [2];
   logic       m_valid [2], m_ill [2];
   logic [4:0] m_wreg [2];
   int         m_st [2];   // 0 run, 1 drain, 2 halted
   int         m_cnt [2];

   function automatic bit model_lu(input int k);
      logic [5:0] op;
      bit rt_use;
      op = instr[31:26];
      rt_use = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b) || (op == 6'h29);
      return id_valid && m_valid[k] && m_ctrl[k].mtr && (m_wreg[k] != 0) &&
             ((m_wreg[k] == instr[25:21]) || (rt_use && (m_wreg[k] == instr[20:16])));
   endfunction

   function automatic void bubble(input int k);
      m_ctrl[k] = '0;
      m_ctrl[k].alu = 4'd13;
      m_valid[k] = 0; m_ill[k] = 0; m_wreg[k] = 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_ctrl[k] = '0; m_valid[k] = 0; m_ill[k] = 0; m_wreg[k] = 0;
            m_st[k] = 0; m_cnt[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            bit    lu;
            int    st;
            string m;
            ctrl_t c;
            lu = model_lu(k);
            st = m_st[k];
            if (st == 0) begin
               if (m_valid[k] && m_ctrl[k].sys && v0_ten && !stall) begin
                  m_st[k] = 1;
                  m_cnt[k] = ((k == 0) ? 3 : 1) - 1;
               end
            end else if (st == 1) begin
               if (m_cnt[k] == 0) m_st[k] = 2;
               else m_cnt[k] = m_cnt[k] - 1;
            end
            if (flush || st != 0) bubble(k);
            else if (stall) ;
            else if (lu) bubble(k);
            else begin
               m = mnem(instr, k == 0, k == 0);
               c = ref_ctrl(m);
               m_ctrl[k]  = c;
               m_valid[k] = id_valid;
               m_ill[k]   = id_valid && (m == "ill");
               m_wreg[k]  = (m == "jal") ? 5'd31 : (c.rd ? instr[15:11] : instr[20:16]);
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input int k, input logic [18:0] c, input logic v, input logic [4:0] w,
                      input logic il, input logic lu, input logic h);
      string p;
      p = (k == 0) ? "dut" : "dut2";
      chk({p, ".ex_ctrl"}, 32'(c), 32'(m_ctrl[k]));
      chk({p, ".ex_valid"}, 32'(v), 32'(m_valid[k]));
      chk({p, ".ex_wreg"}, 32'(w), 32'(m_wreg[k]));
      chk({p, ".ex_illegal"}, 32'(il), 32'(m_ill[k]));
      chk({p, ".load_use"}, 32'(lu), 32'(model_lu(k)));
      chk({p, ".halted"}, 32'(h), 32'(m_st[k] == 2));
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         cmp(0, d0_ctrl, d0_valid, d0_wreg, d0_ill, d0_lu, d0_halt);
         cmp(1, d1_ctrl, d1_valid, d1_wreg, d1_ill, d1_lu, d1_halt);
      end
   end

   task automatic drive(input logic [31:0] ins, input logic v, input logic st = 1'b0,
                        input logic fl = 1'b0, input logic v0 = 1'b0);
      @(posedge clk);
      #2;
      instr = ins; id_valid = v; stall = st; flush = fl; v0_ten = v0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b1; instr = '0; id_valid = 0; stall = 0; flush = 0; v0_ten = 0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      check_en = 1'b1;
      #1;
      chk("reset.ctrl", 32'(d0_ctrl), 32'h0);
      chk("reset.valid", 32'(d0_valid), 32'h0);
      chk("reset.halted", 32'(d0_halt), 32'h0);

      // add decodes one cycle later
      drive(ADD1, 1); drive(0, 0); #1;
      chk("add.ctrl", 32'(d0_ctrl), 32'h154);
      chk("add.wreg", 32'(d0_wreg), 32'd3);
      chk("add.valid", 32'(d0_valid), 32'd1);

      // lw then dependent add: one bubble
      drive(LW, 1); drive(ADD2, 1); #1;
      chk("lu.detect", 32'(d0_lu), 32'd1);
      chk("lw.ctrl", 32'(d0_ctrl), 32'h394);
      drive(ADD2, 1); #1;
      chk("lu.bubble_valid", 32'(d0_valid), 32'd0);
      chk("lu.bubble_ctrl", 32'(d0_ctrl), 32'h34);
      drive(0, 0); #1;
      chk("lu.add_in_ex", 32'(d0_ctrl), 32'h154);
      chk("lu.add_valid", 32'(d0_valid), 32'd1);

      // rt-use only for store; addi rt match and $0 are not hazards
      drive(LW, 1); drive(SW_RT, 1); #1;
      chk("lu.sw_rt", 32'(d0_lu), 32'd1);
      drive(LW, 1); drive(ADDI_RT, 1); #1;
      chk("lu.addi_rt", 32'(d0_lu), 32'd0);
      drive(LW0, 1); drive(ADD0, 1); #1;
      chk("lu.reg0", 32'(d0_lu), 32'd0);

      // stall holds ID/EX
      drive(ORI, 1); drive(ADD1, 1, 1); #1;
      chk("ori.ctrl", 32'(d0_ctrl), 32'h1A1);
      drive(0, 0); #1;
      chk("stall.hold_ctrl", 32'(d0_ctrl), 32'h1A1);
      chk("stall.hold_wreg", 32'(d0_wreg), 32'd5);

      // flush beats stall
      drive(ORI, 1, 1, 1); drive(0, 0); #1;
      chk("flush.valid", 32'(d0_valid), 32'd0);
      chk("flush.ctrl", 32'(d0_ctrl), 32'h34);

      drive(JAL, 1); drive(JR, 1); #1;
      chk("jal.ctrl", 32'(d0_ctrl), 32'h10134);
      chk("jal.wreg", 32'(d0_wreg), 32'd31);
      drive(0, 0); #1;
      chk("jr.ctrl", 32'(d0_ctrl), 32'h20034);

      // sh/blez enabled on dut, illegal on dut2
      drive(SH, 1); drive(0, 0); #1;
      chk("sh.ctrl", 32'(d0_ctrl), 32'hC94);
      chk("sh_off.illegal", 32'(d1_ill), 32'd1);
      chk("sh_off.valid", 32'(d1_valid), 32'd1);
      chk("sh_off.ctrl", 32'(d1_ctrl), 32'h34);
      drive(BLEZ, 1); drive(0, 0); #1;
      chk("blez.ctrl", 32'(d0_ctrl), 32'h1034);
      chk("blez_off.illegal", 32'(d1_ill), 32'd1);

      // exit syscall: drain then halt
      drive(SYS, 1); drive(0, 0, 0, 0, 1); #1;
      chk("sys.ctrl", 32'(d0_ctrl), 32'h40034);
      drive(ADD1, 1); #1;
      chk("drain.e0_halted", 32'(d0_halt), 32'd0);
      drive(ADD1, 1, 1); #1;
      chk("drain.e1_halted", 32'(d0_halt), 32'd0);
      chk("drain1.e1_halted", 32'(d1_halt), 32'd1);
      chk("drain.e1_valid", 32'(d0_valid), 32'd0);
      drive(ADD1, 1); #1;
      chk("drain.e2_halted", 32'(d0_halt), 32'd0);
      drive(ADD1, 1); #1;
      chk("drain.e3_halted", 32'(d0_halt), 32'd1);
      drive(ADD1, 1); #1;
      chk("halted.valid", 32'(d0_valid), 32'd0);

      // reset leaves HALTED
      @(posedge clk); #2 rst_n = 1'b0; #1;
      chk("halt_rst.halted", 32'(d0_halt), 32'd0);
      rst_n = 1'b1;

      // reset mid-drain clears asynchronously
      drive(SYS, 1); drive(0, 0, 0, 0, 1); drive(ADD1, 1); drive(ADD1, 1);
      #1 rst_n = 1'b0; #1;
      chk("drain_rst.ctrl", 32'(d0_ctrl), 32'h0);
      chk("drain_rst.halted", 32'(d0_halt), 32'd0);
      chk("drain_rst.valid", 32'(d0_valid), 32'd0);
      rst_n = 1'b1;
      drive(ADD1, 1); drive(0, 0); #1;
      chk("post_rst.add_ctrl", 32'(d0_ctrl), 32'h154);
      chk("post_rst.add_valid", 32'(d0_valid), 32'd1);

      repeat (4) drive(0, 0);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
